serial_pattern_tx: RTL and testbench

Parallel-to-serial bit-pattern transmitter. Drives single-bit serial streams into the serial sequence-detector FSMs in this codebase.
Accepts a WIDTH-bit word through a Load/Ready handshake and shifts it out MSB-first, one bit per BIT_CYCLES clocks. Signals completion with a one-cycle Done pulse.
All outputs are registered.

---
 rtl/serial_pattern_tx_pkg.sv | 16 +
 rtl/serial_pattern_tx_bit_period_counter.sv | 40 ++++
 rtl/serial_pattern_tx.sv | 144 ++++++++++++++
 tb/tb_serial_pattern_tx.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_pattern_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: FSM encoding and a
// counter width helper.
package serial_pattern_tx_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSend   = 2'd1,
    StFinish = 2'd2
  } tx_state_e;

  // Width of a counter running 0..n-1; never narrower than one bit.
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n <= 1) ? 1 : unsigned'($clog2(n));
  endfunction

endpackage

// File: rtl/serial_pattern_tx_bit_period_counter.sv
// Modulo-PERIOD counter with enable and clear. Wrap is high on the enabled
// cycle where the count is at its last value, i.e. the final cycle of a bit.
module bit_period_counter
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned PERIOD = 1
) (
  input  logic Clk,
  input  logic Reset,
  input  logic En,
  input  logic Clr,
  output logic Wrap
);

  localparam int unsigned CntW = cnt_width(PERIOD);
  localparam logic [CntW-1:0] LastCnt = CntW'(PERIOD - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Wrap pulse and next count; clear wins over enable.
  always_comb begin
    Wrap  = En && (cnt_q == LastCnt);
    cnt_d = cnt_q;
    if (Clr) begin
      cnt_d = '0;
    end else if (En) begin
      cnt_d = Wrap ? '0 : cnt_q + CntW'(1);
    end
  end

  // Count register with synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/serial_pattern_tx.sv
// Parallel-to-serial transmitter: accepts a word on Load/Ready and shifts it
// out MSB-first, BIT_CYCLES clocks per bit, then pulses Done for one cycle.
// Every output is a flop; nothing combinational reaches the ports.
module serial_pattern_tx
  import serial_pattern_tx_pkg::*;
#(
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned BIT_CYCLES = 1,
  parameter logic        IDLE_LEVEL = 1'b0
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             Load,
  input  logic [WIDTH-1:0] Data,
  output logic             Ready,
  output logic             Sout,
  output logic             Frame,
  output logic             Busy,
  output logic             Done
);

  localparam int unsigned BitW = $clog2(WIDTH + 1);
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);

  tx_state_e        state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic             sout_q, sout_d;
  logic             frame_q, frame_d;
  logic             ready_q, ready_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             accept;
  logic             cnt_en;
  logic             cnt_wrap;

  // Acceptance only in idle; the period counter runs only while sending.
  always_comb begin
    accept = (state_q == StIdle) && Load;
    cnt_en = (state_q == StSend);
  end

  bit_period_counter #(
    .PERIOD(BIT_CYCLES)
  ) u_bit_period_counter (
    .Clk  (Clk),
    .Reset(Reset),
    .En   (cnt_en),
    .Clr  (accept),
    .Wrap (cnt_wrap)
  );

  // Next-state and registered-output logic.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    bit_cnt_d = bit_cnt_q;
    sout_d    = sout_q;
    frame_d   = frame_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;

    unique case (state_q)
      StIdle: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
        frame_d = 1'b0;
        sout_d  = IDLE_LEVEL;
        if (Load) begin
          // MSB goes out in the very next cycle, so present it directly.
          shift_d   = Data;
          bit_cnt_d = '0;
          sout_d    = Data[WIDTH-1];
          frame_d   = 1'b1;
          busy_d    = 1'b1;
          ready_d   = 1'b0;
          state_d   = StSend;
        end
      end
      StSend: begin
        if (cnt_wrap) begin
          if (bit_cnt_q == LastBit) begin
            state_d = StFinish;
            sout_d  = IDLE_LEVEL;
            frame_d = 1'b0;
            done_d  = 1'b1;
          end else begin
            shift_d   = {shift_q[WIDTH-2:0], 1'b0};
            sout_d    = shift_q[WIDTH-2];
            bit_cnt_d = bit_cnt_q + BitW'(1);
          end
        end
      end
      StFinish: begin
        state_d   = StIdle;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        shift_d   = '0;
        bit_cnt_d = '0;
      end
      default: begin
        state_d   = StIdle;
        ready_d   = 1'b1;
        busy_d    = 1'b0;
        frame_d   = 1'b0;
        sout_d    = IDLE_LEVEL;
        shift_d   = '0;
        bit_cnt_d = '0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame without Done.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q   <= StIdle;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      sout_q    <= IDLE_LEVEL;
      frame_q   <= 1'b0;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      bit_cnt_q <= bit_cnt_d;
      sout_q    <= sout_d;
      frame_q   <= frame_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign Ready = ready_q;
  assign Sout  = sout_q;
  assign Frame = frame_q;
  assign Busy  = busy_q;
  assign Done  = done_q;

endmodule

// File: tb/tb_serial_pattern_tx.sv
// Bench for serial_pattern_tx: one instance at one cycle per bit, one at
// three cycles per bit. Serial bits are scoreboarded through queues.
module tb_serial_pattern_tx;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       load1, load3;
  logic [7:0] data1, data3;
  logic       ready1, sout1, frame1, busy1, done1;
  logic       ready3, sout3, frame3, busy3, done3;

  int tests = 0;
  int fails = 0;

  bit q1[$];
  bit q3[$];

  int   det_cnt = 0;
  logic det_prev = 1'b0;

  serial_pattern_tx #(
    .WIDTH     (8),
    .BIT_CYCLES(1),
    .IDLE_LEVEL(1'b0)
  ) u_dut1 (
    .Clk  (clk),
    .Reset(rst),
    .Load (load1),
    .Data (data1),
    .Ready(ready1),
    .Sout (sout1),
    .Frame(frame1),
    .Busy (busy1),
    .Done (done1)
  );

  serial_pattern_tx #(
    .WIDTH     (8),
    .BIT_CYCLES(3),
    .IDLE_LEVEL(1'b0)
  ) u_dut3 (
    .Clk  (clk),
    .Reset(rst),
    .Load (load3),
    .Data (data3),
    .Ready(ready3),
    .Sout (sout3),
    .Frame(frame3),
    .Busy (busy3),
    .Done (done3)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // {Ready, Busy, Frame, Done} of the selected instance.
  function automatic logic [3:0] ctl(input logic slow);
    return slow ? {ready3, busy3, frame3, done3} : {ready1, busy1, frame1, done1};
  endfunction

  // Scoreboard: every cycle with Frame=1 consumes one expected bit.
  always @(negedge clk) begin
    bit eb;
    if (frame1) begin
      tests++;
      if (q1.size() == 0) begin
        fails++;
        $display("FAIL sb1_extra: got frame bit %0b, expected no frame", sout1);
      end else begin
        eb = q1.pop_front();
        tests--;
        chk("sb1_sout", {31'd0, sout1}, {31'd0, eb});
      end
      if (sout1 && det_prev) det_cnt++;
      det_prev = sout1;
    end else begin
      det_prev = 1'b0;
    end
    if (frame3) begin
      tests++;
      if (q3.size() == 0) begin
        fails++;
        $display("FAIL sb3_extra: got frame bit %0b, expected no frame", sout3);
      end else begin
        eb = q3.pop_front();
        tests--;
        chk("sb3_sout", {31'd0, sout3}, {31'd0, eb});
      end
    end
  end

  task automatic push_word(input logic slow, input logic [7:0] d, input int nbits);
    int unsigned bc;
    bc = slow ? 3 : 1;
    for (int i = 7; i > 7 - nbits; i--) begin
      for (int r = 0; r < int'(bc); r++) begin
        if (slow) q3.push_back(d[i]);
        else      q1.push_back(d[i]);
      end
    end
  endtask

  task automatic drive(input logic slow, input logic ld, input logic [7:0] d);
    if (slow) begin
      load3 = ld;
      data3 = d;
    end else begin
      load1 = ld;
      data1 = d;
    end
  endtask

  task automatic wait_ready(input logic slow);
    int n;
    n = 0;
    @(negedge clk);
    while (ctl(slow)[3] !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("ready_timeout", {31'd0, ctl(slow)[3]}, 32'd1);
  endtask

  // One full frame, checking control outputs every cycle up to Ready again.
  task automatic run_frame(input logic [7:0] d, input logic slow, input int unsigned dcyc,
                           input logic junk);
    logic [3:0] exp;
    logic       ld;
    wait_ready(slow);
    drive(slow, 1'b1, d);
    push_word(slow, d, 8);
    @(posedge clk);
    for (int c = 0; c <= int'(dcyc) + 1; c++) begin
      @(negedge clk);
      if (c < int'(dcyc))       exp = 4'b0110;
      else if (c == int'(dcyc)) exp = 4'b0101;
      else                      exp = 4'b1000;
      chk($sformatf("ctl_%0h_c%0d", d, c), {28'd0, ctl(slow)}, {28'd0, exp});
      if (c == int'(dcyc)) chk("sout_idle_done", {31'd0, slow ? sout3 : sout1}, 32'd0);
      ld = junk && (c >= 1) && (c <= 9);
      drive(slow, ld, ld ? 8'hFF : ~d);
    end
    drive(slow, 1'b0, 8'h00);
  endtask

  typedef struct {
    logic [7:0]  data;
    logic        slow;
    int unsigned done_cyc;
    logic        junk;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int rise_a, rise_b, dcount;
    logic prev_f;

    vecs[0] = '{8'hB3, 1'b0, 8, 1'b0};
    vecs[1] = '{8'hB3, 1'b1, 24, 1'b1};
    vecs[2] = '{8'h81, 1'b0, 8, 1'b1};
    vecs[3] = '{8'h5A, 1'b1, 24, 1'b0};
    vecs[4] = '{8'h00, 1'b0, 8, 1'b0};
    vecs[5] = '{8'hFF, 1'b0, 8, 1'b0};
    vecs[6] = '{8'h01, 1'b1, 24, 1'b0};

    rst   = 1'b1;
    load1 = 1'b0;
    load3 = 1'b0;
    data1 = 8'h00;
    data3 = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Idle after reset.
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("idle1_c%0d", c), {27'd0, ctl(1'b0), sout1}, {27'd0, 4'b1000, 1'b0});
      chk($sformatf("idle3_c%0d", c), {27'd0, ctl(1'b1), sout3}, {27'd0, 4'b1000, 1'b0});
    end

    for (int v = 0; v < 7; v++) begin
      run_frame(vecs[v].data, vecs[v].slow, vecs[v].done_cyc, vecs[v].junk);
    end

    // Load held high across two frames on the slow instance.
    wait_ready(1'b1);
    drive(1'b1, 1'b1, 8'hB3);
    push_word(1'b1, 8'hB3, 8);
    push_word(1'b1, 8'h5A, 8);
    @(posedge clk);
    rise_a = -1;
    rise_b = -1;
    dcount = 0;
    prev_f = 1'b0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (frame3 && !prev_f) begin
        if (rise_a < 0) rise_a = c;
        else if (rise_b < 0) rise_b = c;
      end
      if (done3) dcount++;
      prev_f = frame3;
      if (c == 0) data3 = 8'h5A;
      if (rise_b >= 0) load3 = 1'b0;
    end
    chk("held_rise_a", rise_a, 0);
    chk("held_rise_b", rise_b, 26);
    chk("held_done_count", dcount, 2);

    // Reset in the middle of a fast frame.
    wait_ready(1'b0);
    drive(1'b0, 1'b1, 8'hB3);
    push_word(1'b0, 8'hB3, 5);
    @(posedge clk);
    for (int c = 0; c <= 4; c++) begin
      @(negedge clk);
      if (c == 0) drive(1'b0, 1'b0, 8'h00);
      if (c == 4) rst = 1'b1;
    end
    @(negedge clk);
    chk("abort_ctl", {27'd0, ctl(1'b0), sout1}, {27'd0, 4'b1000, 1'b0});
    rst = 1'b0;
    dcount = 0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done1) dcount++;
    end
    chk("abort_no_done", dcount, 0);
    run_frame(8'h81, 1'b0, 8, 1'b0);

    // Loopback into a "11" detector.
    det_cnt = 0;
    run_frame(8'hB3, 1'b0, 8, 1'b0);
    chk("det_11_count", det_cnt, 2);

    chk("q1_drained", q1.size(), 0);
    chk("q3_drained", q3.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before 200000");
    $fatal(1, "watchdog");
  end

endmodule
